// File: rtl/obc_da_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : obc_da_accumulator
// Purpose  : Offset-binary-coded distributed-arithmetic accumulator. Streams
//            16 captured W-bit samples MSB-first as bit-slices to an external
//            OBC ROM and accumulates the returned partial sums into one signed
//            DFT output word.
// Revision : 1.0 - initial release
// ============================================================================
module obc_da_accumulator #(
  parameter int W  = 8,
  parameter int RW = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*W-1:0]      samples,
  input  logic signed [RW-1:0] offset_const,
  output logic [15:0]          slice,
  output logic                 m,
  input  logic signed [RW-1:0] romout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [RW+W-1:0] result
);

  localparam int AW = RW + W;
  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] IDX_MSB = IW'(W - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]            state_q,     state_d;
  logic [15:0][W-1:0]    samples_q,   samples_d;
  logic signed [AW-1:0]  acc_q,       acc_d;
  logic [IW-1:0]         idx_q,       idx_d;
  logic signed [AW-1:0]  result_q,    result_d;
  logic                  out_valid_q, out_valid_d;

  logic signed [AW-1:0]  w_rom_ext;
  logic signed [AW-1:0]  w_off_ext;
  logic signed [AW-1:0]  w_acc_sum;
  logic signed [AW-1:0]  w_res_full;
  logic signed [AW-1:0]  w_result;

  // The ROM already returns the MSB-cycle term negated, so the datapath is a
  // plain shift-and-add; the OBC offset is removed once, on the final cycle.
  assign w_rom_ext  = {{W{romout[RW-1]}}, romout};
  assign w_off_ext  = {{W{offset_const[RW-1]}}, offset_const};
  assign w_acc_sum  = (acc_q <<< 1) + w_rom_ext;
  assign w_res_full = w_acc_sum - w_off_ext;
  assign w_result   = w_res_full >>> 1;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

  // Present the current bit column of the captured samples to the ROM.
  always_comb begin
    slice = '0;
    m     = 1'b0;
    if (state_q == ST_SHIFT) begin
      for (int k = 0; k < 16; k++) begin
        slice[k] = samples_q[k][idx_q];
      end
      m = (idx_q == IDX_MSB);
    end
  end

  // Next-state logic: capture in IDLE, accumulate in SHIFT, hold in DONE.
  always_comb begin
    state_d     = state_q;
    samples_d   = samples_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          samples_d = samples;
          acc_d     = '0;
          idx_d     = IDX_MSB;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d = w_acc_sum;
        if (idx_q == '0) begin
          result_d    = w_result;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; asynchronous reset aborts any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      samples_q   <= '0;
      acc_q       <= '0;
      idx_q       <= IDX_MSB;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      samples_q   <= samples_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/obc_da_accumulator.md
OBC_DA_ACCUMULATOR -- requirements
Module: obc_da_accumulator

Interface
REQ-001 Parameter W, default 8: two's-complement sample width, and the number of bit-slice cycles per transform.
REQ-002 Parameter RW, default 32: width of the signed partial-sum word returned by the OBC ROM.
REQ-003 Reset is asynchronous and active-low; one clock domain.
REQ-004 Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sample block valid.
- in_ready  out  1  block accepted when in_valid && in_ready.
- samples  in  16*W  sample k occupies bits [k*W+W-1 : k*W].
- offset_const  in  RW  signed OBC offset term; must be stable while busy.
- slice  out  16  bit-slice to ROM; slice[k] = current bit of sample k.
- m  out  1  MSB-cycle flag to ROM.
- romout  in  RW  signed combinational ROM partial sum for current slice/m.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- result  out  RW+W  signed DFT output word.

Function
REQ-005 FSM states IDLE, SHIFT, DONE; in_ready SHALL be 1 only in IDLE.
REQ-006 IDLE: on in_valid && in_ready, capture all 16 samples, clear the accumulator, set bit index idx=W-1, and go to SHIFT.
REQ-007 SHIFT: slice[k] SHALL equal bit idx of captured sample k; m SHALL be 1 iff idx==W-1 (MSB cycle first).
REQ-008 Outside SHIFT, slice and m SHALL be driven 0.
REQ-009 Each SHIFT edge: acc <= (acc <<< 1) + sign_extend(romout); acc is signed, RW+W bits wide; overflow is impossible by construction.
REQ-010 SHIFT edge with idx==0: result <= ((acc <<< 1) + romout - sign_extend(offset_const)) >>> 1 (arithmetic shift), out_valid <= 1, state <= DONE. Otherwise idx decrements.
REQ-011 Latency: exactly W rising edges from the acceptance edge to out_valid high; W SHIFT cycles per block.
REQ-012 DONE: result and out_valid SHALL hold stable until out_valid && out_ready, then go to IDLE with out_valid <= 0. result keeps its last value.
REQ-013 Back-to-back blocks: a new block is accepted no earlier than the cycle after DONE exits. Minimum period is W+2 cycles.
REQ-014 in_valid is ignored outside IDLE; samples changing outside IDLE SHALL NOT affect the computation.
REQ-015 romout is sampled every SHIFT cycle, including all-zero slices; the block SHALL apply no special-casing of romout.
REQ-016 out_ready is ignored outside DONE.

Reset
REQ-017 rst_n low, asynchronously:
- state=IDLE, acc=0, idx=W-1, captured samples=0.
- result=0, out_valid=0, slice=0, m=0.
- in_ready=1 once rst_n is high.
REQ-018 Reset asserted mid-SHIFT or in DONE SHALL abort the block with no output. The first post-reset block SHALL compute correctly.

Verification
REQ-019 Bench SHALL cover these directed scenarios (W=8, RW=32):
- ROM stub romout=1 every cycle, offset 0 -> acc=255, result=127, out_valid 8 edges after acceptance.
- ROM stub romout=-1 when m=1, else +1, offset 0 -> acc=-128+127=-1, result=-1.
- Real OBC ROM model, samples all 0x7F with all-ones coefficients vs. golden DFT model -> bit-exact result.
- out_ready held low 5 cycles in DONE -> result/out_valid stable, in_ready=0, in_valid ignored; accept on 6th cycle -> IDLE.
- rst_n pulsed low at SHIFT idx=3 -> all outputs 0 immediately; next block yields correct result.
- slice/m trace for samples[k]=k -> MSB-first slice sequence matches bit columns; m high only on first SHIFT cycle.
